// File: rtl/xsr_rx_if.sv
// Host-side pop port of the serial receiver: head frame, framing error and valid/ready handshake.
interface xsr_rx_if #(
  parameter int SR_WIDTH = 64
) ();
  logic [SR_WIDTH-1:0] dat_o;
  logic                ferr_o;
  logic                valid_o;
  logic                ready_i;

  modport master (output dat_o, output ferr_o, output valid_o, input ready_i);
  modport slave  (input dat_o, input ferr_o, input valid_o, output ready_i);
endinterface

// File: rtl/xsr_rx.sv
// Serial receive shifter with internal-divisor or external-bit-clock sampling,
// programmable frame length and a small receive FIFO with overrun reporting.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a start bit (falling rxd, or rxc edge with rxd=0)
// S_START | half-bit delay before confirming the start bit (internal mode)
// S_DATA  | sampling the remaining frame bits
// S_DONE  | one cycle: push the assembled frame, reload the shifter
module xsr_rx #(
  parameter int SR_WIDTH   = 64,
  parameter int BITS_W     = 6,
  parameter int BAUD_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [BITS_W-1:0] bits_i,
  input  logic [BAUD_W-1:0] baud_i,
  input  logic              ext_i,
  input  logic              rxd_i,
  input  logic              rxc_i,
  xsr_rx_if.master          pop,
  output logic              overrun_o,
  input  logic              ovr_clr_i,
  output logic              idle_o,
  output logic              sample_to
);

  localparam int NW = $clog2(SR_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_DONE} state_t;

  state_t              state, state_d;
  logic [SR_WIDTH-1:0] sr, sr_d;
  logic [BAUD_W-1:0]   cnt, cnt_d;
  logic [BAUD_W-1:0]   baud_r, baud_d;
  logic [NW-1:0]       bit_cnt, bit_cnt_d;
  logic [NW-1:0]       nbits, nbits_d;
  logic [NW-1:0]       n_eff;
  logic                ext_r, ext_d;
  logic                sample, push, tick;

  logic rxd_m, rxd_s, rxd_q;
  logic rxc_m, rxc_s, rxc_q;
  logic rxd_fall, rxc_rise;

  // Two-flop synchronisers plus one extra stage for edge detection
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_q <= 1'b1;
      rxc_m <= 1'b0;
      rxc_s <= 1'b0;
      rxc_q <= 1'b0;
    end else begin
      rxd_m <= rxd_i;
      rxd_s <= rxd_m;
      rxd_q <= rxd_s;
      rxc_m <= rxc_i;
      rxc_s <= rxc_m;
      rxc_q <= rxc_s;
    end
  end

  assign rxd_fall = rxd_q & ~rxd_s;
  assign rxc_rise = rxc_s & ~rxc_q;

  always_comb begin
    n_eff = '0;
    if (int'(bits_i) < 2)
      n_eff = NW'(2);
    else if (int'(bits_i) > SR_WIDTH)
      n_eff = NW'(SR_WIDTH);
    else
      n_eff = NW'(bits_i);
  end

  always_comb begin
    state_d   = state;
    sr_d      = sr;
    cnt_d     = cnt;
    baud_d    = baud_r;
    bit_cnt_d = bit_cnt;
    nbits_d   = nbits;
    ext_d     = ext_r;
    sample    = 1'b0;
    push      = 1'b0;
    tick      = 1'b0;
    case (state)
      S_IDLE: begin
        ext_d = ext_i;
        if (ext_i) begin
          if (rxc_rise) begin
            sample = 1'b1;
            if (!rxd_s) begin
              sr_d      = {1'b0, sr[SR_WIDTH-1:1]};
              bit_cnt_d = NW'(1);
              nbits_d   = n_eff;
              state_d   = S_DATA;
            end
          end
        end else if (rxd_fall) begin
          cnt_d   = baud_i >> 1;
          baud_d  = baud_i;
          nbits_d = n_eff;
          state_d = S_START;
        end
      end
      S_START: begin
        if (ext_i != ext_r) begin
          sr_d    = '1;
          state_d = S_IDLE;
        end else if (cnt == '0) begin
          sample = 1'b1;
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            sr_d      = {1'b0, sr[SR_WIDTH-1:1]};
            bit_cnt_d = NW'(1);
            cnt_d     = baud_r;
            state_d   = S_DATA;
          end
        end else begin
          cnt_d = cnt - BAUD_W'(1);
        end
      end
      S_DATA: begin
        tick = ext_r ? rxc_rise : (cnt == '0);
        if (ext_i != ext_r) begin
          sr_d    = '1;
          state_d = S_IDLE;
        end else if (tick) begin
          sample    = 1'b1;
          sr_d      = {rxd_s, sr[SR_WIDTH-1:1]};
          bit_cnt_d = bit_cnt + NW'(1);
          cnt_d     = baud_r;
          if (bit_cnt + NW'(1) == nbits)
            state_d = S_DONE;
        end else if (!ext_r) begin
          cnt_d = cnt - BAUD_W'(1);
        end
      end
      S_DONE: begin
        push    = 1'b1;
        sr_d    = '1;
        state_d = S_IDLE;
      end
      default: begin
        sr_d    = '1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= S_IDLE;
      sr        <= '1;
      cnt       <= '0;
      baud_r    <= '0;
      bit_cnt   <= '0;
      nbits     <= NW'(2);
      ext_r     <= 1'b0;
      sample_to <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      cnt       <= cnt_d;
      baud_r    <= baud_d;
      bit_cnt   <= bit_cnt_d;
      nbits     <= nbits_d;
      ext_r     <= ext_d;
      sample_to <= sample;
    end
  end

  assign idle_o = (state == S_IDLE);

  // Receive FIFO; a full FIFO still accepts a push when the head is popped in the same cycle
  logic [SR_WIDTH-1:0] mem_dat  [FIFO_DEPTH];
  logic                mem_ferr [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, do_pop, do_push, drop;
  logic [SR_WIDTH-1:0] word;

  assign word    = sr >> (SR_WIDTH - int'(nbits));
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop.valid_o & pop.ready_i;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
      if (drop)
        overrun_o <= 1'b1;
      else if (ovr_clr_i)
        overrun_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_dat[wr_ptr]  <= word;
      mem_ferr[wr_ptr] <= ~sr[SR_WIDTH-1];
    end
  end

  assign pop.valid_o = (count != '0);
  assign pop.dat_o   = pop.valid_o ? mem_dat[rd_ptr] : '0;
  assign pop.ferr_o  = pop.valid_o ? mem_ferr[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_xsr_rx.sv
// Directed bench for xsr_rx: internal and external framing, false start, framing error,
// frame-length clamping, FIFO overrun and same-cycle push/pop, mid-frame reset.
`timescale 1ns/1ps
module tb_xsr_rx;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [5:0]  bits_i = 6'd11;
  logic [63:0] baud_i = 64'd49;
  logic        ext_i = 1'b0;
  logic        rxd_i = 1'b1;
  logic        rxc_i = 1'b0;
  logic        overrun_o, ovr_clr_i = 1'b0, idle_o, sample_to;

  int total = 0;
  int bad = 0;
  int n_samp = 0;
  int n0;
  int k;

  xsr_rx_if #(.SR_WIDTH(64)) bus ();

  xsr_rx dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .bits_i    (bits_i),
    .baud_i    (baud_i),
    .ext_i     (ext_i),
    .rxd_i     (rxd_i),
    .rxc_i     (rxc_i),
    .pop       (bus),
    .overrun_o (overrun_o),
    .ovr_clr_i (ovr_clr_i),
    .idle_o    (idle_o),
    .sample_to (sample_to)
  );

  always #10 clk_i = ~clk_i;

  always @(posedge clk_i) if (sample_to) n_samp <= n_samp + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_int(input logic [63:0] pat, input int n, input int bit_ns);
    for (int i = 0; i < n; i++) begin
      rxd_i = pat[i];
      #(bit_ns);
    end
    rxd_i = 1'b1;
  endtask

  task automatic send_ext(input logic [63:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_i = pat[i];
      #60 rxc_i = 1'b1;
      #80 rxc_i = 1'b0;
      #60;
    end
    rxd_i = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk_i);
    bus.ready_i = 1'b1;
    @(negedge clk_i);
    bus.ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    logic [63:0] exp_q [4];
    bus.ready_i = 1'b0;
    #95 reset_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_overrun", overrun_o, 1'b0);
    chk("rst_dat", bus.dat_o, 64'h0);
    chk("rst_ferr", bus.ferr_o, 1'b0);
    chk("rst_sample", sample_to, 1'b0);

    // internal 8O1 frame
    n0 = n_samp;
    send_int(64'h50A, 11, 1000);
    repeat (3) @(negedge clk_i);
    chk("int_valid", bus.valid_o, 1'b1);
    chk("int_dat", bus.dat_o, 64'h50A);
    chk("int_ferr", bus.ferr_o, 1'b0);
    chk("int_nsamp", 64'(n_samp - n0), 64'd11);
    repeat (20) @(negedge clk_i);
    chk("int_hold_dat", bus.dat_o, 64'h50A);
    pop_one();
    chk("int_popped", bus.valid_o, 1'b0);

    // false start
    n0 = n_samp;
    rxd_i = 1'b0;
    #300 rxd_i = 1'b1;
    #1500;
    @(negedge clk_i);
    chk("fs_nsamp", 64'(n_samp - n0), 64'd1);
    chk("fs_idle", idle_o, 1'b1);
    chk("fs_valid", bus.valid_o, 1'b0);

    // framing error: stop bit 0
    send_int(64'h10A, 11, 1000);
    repeat (3) @(negedge clk_i);
    chk("fe_dat", bus.dat_o, 64'h10A);
    chk("fe_ferr", bus.ferr_o, 1'b1);
    pop_one();

    // short frames: 4 bits, and bits_i=1 clamped to 2
    bits_i = 6'd4;
    baud_i = 64'd9;
    send_int(64'hE, 4, 200);
    repeat (3) @(negedge clk_i);
    chk("n4_dat", bus.dat_o, 64'hE);
    chk("n4_ferr", bus.ferr_o, 1'b0);
    pop_one();
    bits_i = 6'd1;
    send_int(64'h2, 2, 200);
    repeat (3) @(negedge clk_i);
    chk("n2_dat", bus.dat_o, 64'h2);
    chk("n2_ferr", bus.ferr_o, 1'b0);
    pop_one();
    chk("n2_empty", bus.valid_o, 1'b0);

    // overrun: five frames into a four-entry FIFO
    bits_i = 6'd11;
    baud_i = 64'd49;
    send_int(64'h402, 11, 1000);
    send_int(64'h404, 11, 1000);
    send_int(64'h7FE, 11, 1000);
    send_int(64'h400, 11, 1000);
    @(negedge clk_i);
    chk("ovr_none_yet", overrun_o, 1'b0);
    send_int(64'h6AA, 11, 1000);
    @(negedge clk_i);
    chk("ovr_set", overrun_o, 1'b1);
    chk("ovr_head", bus.dat_o, 64'h402);
    ovr_clr_i = 1'b1;
    @(negedge clk_i);
    ovr_clr_i = 1'b0;
    chk("ovr_clr", overrun_o, 1'b0);

    // push while full with a pop in the same cycle
    fork
      send_int(64'h5F0, 11, 1000);
      begin
        k = 0;
        for (int c = 0; c < 2000 && k < 11; c++) begin
          @(negedge clk_i);
          if (sample_to) k++;
        end
        chk("pp_sync_budget", 64'(k), 64'd11);
        bus.ready_i = 1'b1;
        @(negedge clk_i);
        bus.ready_i = 1'b0;
      end
    join
    @(negedge clk_i);
    chk("pp_no_overrun", overrun_o, 1'b0);
    exp_q[0] = 64'h404;
    exp_q[1] = 64'h7FE;
    exp_q[2] = 64'h400;
    exp_q[3] = 64'h5F0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fifo_order%0d", i), bus.dat_o, exp_q[i]);
      chk($sformatf("fifo_valid%0d", i), bus.valid_o, 1'b1);
      pop_one();
    end
    chk("fifo_drained", bus.valid_o, 1'b0);

    // external bit clock
    ext_i = 1'b1;
    repeat (4) @(negedge clk_i);
    n0 = n_samp;
    send_ext(64'h50A, 11);
    repeat (3) @(negedge clk_i);
    chk("ext_dat", bus.dat_o, 64'h50A);
    chk("ext_ferr", bus.ferr_o, 1'b0);
    chk("ext_nsamp", 64'(n_samp - n0), 64'd11);

    // reset in the middle of a second external frame
    send_ext(64'h50A, 5);
    @(negedge clk_i);
    chk("mid_busy", idle_o, 1'b0);
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_idle", idle_o, 1'b1);
    chk("mid_rst_valid", bus.valid_o, 1'b0);
    chk("mid_rst_dat", bus.dat_o, 64'h0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("post_rst_idle", idle_o, 1'b1);
    chk("post_rst_valid", bus.valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
